// File: rtl/sqrt_arbiter.sv
// ---------------------------------------------------------------------------
// sqrt_arbiter
//   Shares one external combinational square-root unit between NUM_REQ
//   requesters. Requesters are granted round-robin. The granted operand is
//   registered onto sq_num. The unit's sq_root is captured one cycle later
//   and held as a valid/ready response until the consumer accepts it.
//
// Parameters
//   NUM_REQ   : number of requesters (2..8)
//   WIDTH     : operand width
//   OUT_WIDTH : root width (WIDTH/2)
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   req_valid  : per-requester operand valid
//   req_data   : operands, requester k at [k*WIDTH +: WIDTH]
//   req_ready  : one-hot accept strobe, combinational, IDLE only
//   sq_num     : registered operand to the external sqrt unit
//   sq_root    : root returned by the external sqrt unit
//   rsp_valid  : result valid
//   rsp_ready  : consumer accepts result
//   rsp_data   : floor(sqrt(operand))
//   rsp_id     : index of the requester owning rsp_data
//   rsp_count  : (SQRT_ARB_COUNT_EN only) 16-bit wrapping handshake counter
//
// Optional feature macro: SQRT_ARB_COUNT_EN
// ---------------------------------------------------------------------------
module sqrt_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           sq_num,
  input  logic [OUT_WIDTH-1:0]       sq_root,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [OUT_WIDTH-1:0]       rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id
`ifdef SQRT_ARB_COUNT_EN
  ,
  output logic [15:0]                rsp_count
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] pick;
  logic           found;
  logic           do_grant;
  logic           handshake;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    pick  = last_grant;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // req_ready is gated by rst_n so it reads 0 the instant reset asserts,
  // even while requesters keep req_valid high.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    do_grant  = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (found && rst_n) begin
          do_grant        = 1'b1;
          req_ready[pick] = 1'b1;
          state_nx        = CALC;
        end
      end
      CALC: state_nx = RESP;
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          handshake = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDW'(NUM_REQ - 1);
      sq_num     <= '0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      if (do_grant) begin
        last_grant <= pick;
        sq_num     <= req_data[pick*WIDTH +: WIDTH];
        rsp_id     <= pick;
      end
      if (state == CALC) begin
        rsp_data  <= sq_root;
        rsp_valid <= 1'b1;
      end
      if (handshake) rsp_valid <= 1'b0;
    end
  end

`ifdef SQRT_ARB_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rsp_count <= '0;
    else if (handshake) rsp_count <= rsp_count + 16'd1;
  end
`else
  // No response counter in the default build.
`endif

endmodule

// File: tb/tb_sqrt_arbiter.sv
module tb_sqrt_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int OW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*W-1:0]    req_data;
  logic [N-1:0]      req_ready;
  logic [W-1:0]      sq_num;
  logic [OW-1:0]     sq_root;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [OW-1:0]     rsp_data;
  logic [1:0]        rsp_id;
`ifdef SQRT_ARB_COUNT_EN
  logic [15:0]       rsp_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sqrt_arbiter #(.NUM_REQ(N), .WIDTH(W), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .sq_num(sq_num), .sq_root(sq_root),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id)
`ifdef SQRT_ARB_COUNT_EN
    , .rsp_count(rsp_count)
`endif
  );

  // Floor integer square root by binary search.
  function automatic logic [15:0] isqrt(input logic [31:0] n);
    longint unsigned lo, hi, mid;
    lo = 0; hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(n)) lo = mid;
      else hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  // External combinational sqrt unit.
  always_comb sq_root = isqrt(sq_num);

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; req_data = '1; rsp_ready = 1'b1;
    cyc(); #1;
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || rsp_data !== '0 ||
        rsp_id !== 2'd0 || sq_num !== '0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b data=%0d id=%0d num=%0d want all 0",
               req_ready, rsp_valid, rsp_data, rsp_id, sq_num);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    cyc(); req_valid = 4'b0001; req_data[31:0] = 32'd144; #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_grant: got %b want 0001", req_ready);
    end
    cyc(); req_valid = '0; #1;
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || sq_num !== 32'd144) begin
      errors++;
      $display("FAIL single_calc: ready=%b valid=%b num=%0d want 0000 0 144",
               req_ready, rsp_valid, sq_num);
    end
    cyc(); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'd12 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL single_resp: valid=%b data=%0d id=%0d want 1 12 0",
               rsp_valid, rsp_data, rsp_id);
    end
    rsp_ready = 1'b1;
    cyc(); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_clear: valid=%b want 0", rsp_valid);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int got[5];
    int n = 0;
    do_reset();
    cyc();
    for (int k = 0; k < N; k++) req_data[k*W +: W] = 32'(k * 100 + 7);
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int c = 0; c < 40 && n < 5; c++) begin
      #1;
      if (req_ready != '0) begin
        for (int k = 0; k < N; k++) if (req_ready[k]) got[n] = k;
        n++;
      end
      cyc();
    end
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL rr_count: got %0d grants want 5", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] != exp_order[i]) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, got[i], exp_order[i]);
      end
    end
    req_valid = '0; rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int c;
    do_reset();
    cyc(); req_valid = 4'b0001; req_data[31:0] = 32'd10000; rsp_ready = 1'b0;
    cyc(); req_valid = 4'b1110; req_data = {4{32'd50}};
    c = 0;
    #1;
    while (rsp_valid !== 1'b1 && c < 10) begin cyc(); #1; c++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_wait: rsp_valid=%b want 1 within 10 cycles", rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'd100 || rsp_id !== 2'd0 || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%0d id=%0d ready=%b want 1 100 0 0000",
                 i, rsp_valid, rsp_data, rsp_id, req_ready);
      end
      cyc(); #1;
    end
    rsp_ready = 1'b1;
    cyc(); rsp_ready = 1'b0; #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b want 0 0010", rsp_valid, req_ready);
    end
    req_valid = '0;
    do_reset();
  endtask

  task automatic test_boundary();
    logic [31:0] ops[3]  = '{32'd0, 32'hFFFF_FFFF, 32'd15};
    logic [15:0] roots[3] = '{16'd0, 16'd65535, 16'd3};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(); req_valid = 4'b0100; req_data[2*W +: W] = ops[i]; rsp_ready = 1'b0;
      cyc(); req_valid = '0;
      cyc(); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== roots[i] || rsp_id !== 2'd2) begin
        errors++;
        $display("FAIL boundary[%0d]: op=%h valid=%b data=%0d id=%0d want 1 %0d 2",
                 i, ops[i], rsp_valid, rsp_data, rsp_id, roots[i]);
      end
      rsp_ready = 1'b1;
      cyc(); rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_reset();
    cyc(); req_valid = 4'b1000; req_data[3*W +: W] = 32'd81;
    cyc(); rst_n = 1'b0; #1;   // state is CALC here
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || rsp_data !== '0 ||
        rsp_id !== 2'd0 || sq_num !== '0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b valid=%b data=%0d id=%0d num=%0d want all 0",
               req_ready, rsp_valid, rsp_data, rsp_id, sq_num);
    end
    req_valid = '0;
    cyc(); rst_n = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin cyc(); #1; if (rsp_valid === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_mid_norsp: %0d response cycles want 0", seen);
    end
    rsp_ready = 1'b0;
  endtask

  // Randomized traffic checked against a transaction-level scoreboard.
  task automatic test_random();
    int          last = N - 1;
    bit          busy = 0;
    int          age  = 0;
    int          pick;
    int          exp_id;
    logic [15:0] exp_root;
    int          done = 0;
    logic [N-1:0] exp_ready;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      cyc();
      req_valid = N'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) req_data[k*W +: W] = $urandom;
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (!busy) begin
        exp_ready = '0;
        if (req_valid != '0) begin
          pick = -1;
          for (int i = 1; i <= N && pick < 0; i++)
            if (req_valid[(last + i) % N]) pick = (last + i) % N;
          exp_ready[pick] = 1'b1;
        end
        checks++;
        if (req_ready !== exp_ready || rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_grant c%0d: ready=%b valid=%b want %b 0",
                   c, req_ready, rsp_valid, exp_ready);
        end
        if (exp_ready != '0) begin
          last = pick; exp_id = pick;
          exp_root = isqrt(req_data[pick*W +: W]);
          busy = 1; age = 0;
        end
      end else begin
        age++;
        checks++;
        if (req_ready !== 4'b0) begin
          errors++; $display("FAIL rand_busy c%0d: ready=%b want 0000", c, req_ready);
        end
        if (age == 1) begin
          checks++;
          if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rand_latency c%0d: valid=%b want 0", c, rsp_valid);
          end
        end else begin
          checks++;
          if (rsp_valid !== 1'b1 || rsp_data !== exp_root || rsp_id !== 2'(exp_id)) begin
            errors++;
            $display("FAIL rand_resp c%0d: valid=%b data=%0d id=%0d want 1 %0d %0d",
                     c, rsp_valid, rsp_data, rsp_id, exp_root, exp_id);
          end
          if (rsp_ready) begin busy = 0; done++; end
        end
      end
    end
`ifdef SQRT_ARB_COUNT_EN
    checks++;
    if (rsp_count !== 16'(done - (rsp_valid && rsp_ready ? 1 : 0))) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", rsp_count, done);
    end
`endif
    checks++;
    if (done < 20) begin
      errors++; $display("FAIL rand_progress: %0d responses want >= 20", done);
    end
    req_valid = '0; rsp_ready = 1'b0;
  endtask

  initial begin
    req_valid = '0; req_data = '0; rsp_ready = 1'b0; rst_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
